// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: frame sequencer states,
// frame error codes, the ceil-log2 helper used to size counters, and the
// bit-timer / timeout limit formulas shared with the UART receiver and
// transmitter.
// ----------------------------------------------------------------------------
package uart_pkg;

   // Frame sequencer states
   typedef enum logic [1:0] {
      S_SYNC    = 2'd0,
      S_LEN     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CHK     = 2'd3
   } state_t;

   // Frame error causes reported on err_code_o
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CHK  = 2'b10;
   localparam logic [1:0] ERR_TO   = 2'b11;

   // Start + 8 data + stop
   localparam int unsigned LP_BITS_PER_BYTE = 10;

   // Bits needed to hold the values 0..value-1 (never less than 1)
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 1) ? value - 1 : 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Clocks per UART bit
   function automatic int unsigned bit_limit(input int unsigned clkfreq,
                                             input int unsigned baudrate);
      return clkfreq / baudrate;
   endfunction

   // Clocks allowed between two received bytes before a frame is abandoned
   function automatic int unsigned timeout_limit(input int unsigned clkfreq,
                                                 input int unsigned baudrate,
                                                 input int unsigned tobytes);
      return tobytes * LP_BITS_PER_BYTE * bit_limit(clkfreq, baudrate);
   endfunction

   // Increment that sticks at 255
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// ----------------------------------------------------------------------------
// uart_timeout_cnt
// Inter-byte timeout counter. Counts every enabled cycle, clears on i_clr.
// o_expire_c is a one-cycle combinational strobe raised in the cycle whose
// closing edge would bring the count to P_LIMIT-1, so a registered consumer
// shows the timeout exactly P_LIMIT cycles after the last clear. A clear in
// the same cycle suppresses the strobe.
//
// Ports:
//   clk         in  system clock
//   rst_n_i     in  synchronous active-low reset
//   i_clr       in  clear count (has priority over enable)
//   i_en        in  count enable
//   o_expire_c  out one-cycle expiry strobe (combinational)
// ----------------------------------------------------------------------------
module uart_timeout_cnt
   import uart_pkg::*;
#(
   parameter int unsigned P_LIMIT = 34_720
) (
   input  logic clk,
   input  logic rst_n_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire_c
);

   localparam int unsigned LP_W    = clogb2(P_LIMIT);
   localparam int unsigned LP_TERM = (P_LIMIT > 2) ? P_LIMIT - 2 : 0;

   logic [LP_W-1:0] r_cnt;

   // Count register
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + LP_W'(1);
      end
   end

   // Fires one cycle before the count reaches P_LIMIT-1
   assign o_expire_c = i_en && !i_clr && (r_cnt == LP_W'(LP_TERM));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Frame sequencer behind the UART receiver. Parses SYNC, LEN, LEN payload
// bytes, CHK (XOR of LEN and payload), forwards payload bytes with their
// index, reports frame pass/fail, enforces an inter-byte timeout and keeps a
// saturating error counter.
//
// Ports:
//   clk             in  system clock
//   rst_n_i         in  synchronous active-low reset
//   rx_data_i[7:0]  in  received byte, valid with rx_done_tick_i
//   rx_done_tick_i  in  one-cycle byte-received strobe
//   byte_o[7:0]     out payload byte
//   byte_valid_o    out one-cycle strobe per payload byte
//   byte_idx_o[7:0] out 0-based payload index of byte_o
//   frame_ok_o      out one-cycle strobe, frame complete and checksum good
//   frame_err_o     out one-cycle strobe, frame aborted
//   err_code_o[1:0] out last abort cause (01 len, 10 checksum, 11 timeout)
//   err_cnt_o[7:0]  out number of aborts, saturating at 255
//   busy_o          out high while a frame is in progress
// ----------------------------------------------------------------------------
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned P_CLKFREQ  = 100_000_000,
   parameter int unsigned P_BAUDRATE = 115_200,
   parameter int unsigned P_MAXLEN   = 16,
   parameter logic [7:0]  P_SYNC     = 8'hA5,
   parameter int unsigned P_TOBYTES  = 4
) (
   input  logic       clk,
   input  logic       rst_n_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_done_tick_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_idx_o,
   output logic       frame_ok_o,
   output logic       frame_err_o,
   output logic [1:0] err_code_o,
   output logic [7:0] err_cnt_o,
   output logic       busy_o
);

   localparam int unsigned LP_TO_LIMIT = timeout_limit(P_CLKFREQ, P_BAUDRATE, P_TOBYTES);
   localparam logic [7:0]  LP_MAXLEN   = 8'(P_MAXLEN);

   state_t     r_state;
   logic [7:0] r_len;
   logic [7:0] r_idx;
   logic [7:0] r_chk;
   logic [7:0] r_byte;
   logic       r_byte_valid;
   logic [7:0] r_byte_idx;
   logic       r_frame_ok;
   logic       r_frame_err;
   logic [1:0] r_err_code;
   logic [7:0] r_err_cnt;
   logic       r_busy;

   logic       w_tmo_en;
   logic       w_tmo_clr;
   logic       w_tmo_expire;

   // Timer runs only inside a frame and restarts on every received byte
   assign w_tmo_en  = (r_state != S_SYNC);
   assign w_tmo_clr = rx_done_tick_i || !w_tmo_en;

   uart_timeout_cnt #(
      .P_LIMIT (LP_TO_LIMIT)
   ) u_timeout (
      .clk        (clk),
      .rst_n_i    (rst_n_i),
      .i_clr      (w_tmo_clr),
      .i_en       (w_tmo_en),
      .o_expire_c (w_tmo_expire)
   );

   // Frame FSM with registered outputs; a received byte beats a coincident timeout
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         r_state      <= S_SYNC;
         r_len        <= 8'd0;
         r_idx        <= 8'd0;
         r_chk        <= 8'd0;
         r_byte       <= 8'd0;
         r_byte_valid <= 1'b0;
         r_byte_idx   <= 8'd0;
         r_frame_ok   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_err_code   <= ERR_NONE;
         r_err_cnt    <= 8'd0;
         r_busy       <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_frame_ok   <= 1'b0;
         r_frame_err  <= 1'b0;

         if (rx_done_tick_i) begin
            case (r_state)
               S_SYNC: begin
                  // Anything but SYNC is line noise between frames
                  if (rx_data_i == P_SYNC) begin
                     r_state <= S_LEN;
                     r_busy  <= 1'b1;
                     r_chk   <= 8'd0;
                  end
               end

               S_LEN: begin
                  r_len <= rx_data_i;
                  r_chk <= rx_data_i;
                  if (rx_data_i == 8'd0) begin
                     r_state <= S_CHK;
                  end else if (rx_data_i > LP_MAXLEN) begin
                     r_state     <= S_SYNC;
                     r_busy      <= 1'b0;
                     r_frame_err <= 1'b1;
                     r_err_code  <= ERR_LEN;
                     r_err_cnt   <= sat_inc8(r_err_cnt);
                  end else begin
                     r_state <= S_PAYLOAD;
                     r_idx   <= 8'd0;
                  end
               end

               S_PAYLOAD: begin
                  // SYNC-valued bytes here are plain data
                  r_byte       <= rx_data_i;
                  r_byte_idx   <= r_idx;
                  r_byte_valid <= 1'b1;
                  r_chk        <= r_chk ^ rx_data_i;
                  r_idx        <= r_idx + 8'd1;
                  if (r_idx == (r_len - 8'd1)) begin
                     r_state <= S_CHK;
                  end
               end

               S_CHK: begin
                  r_state <= S_SYNC;
                  r_busy  <= 1'b0;
                  if (rx_data_i == r_chk) begin
                     r_frame_ok <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= ERR_CHK;
                     r_err_cnt   <= sat_inc8(r_err_cnt);
                  end
               end

               default: begin
                  r_state <= S_SYNC;
                  r_busy  <= 1'b0;
               end
            endcase
         end else if (w_tmo_expire) begin
            r_state     <= S_SYNC;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TO;
            r_err_cnt   <= sat_inc8(r_err_cnt);
         end
      end
   end

   assign byte_o       = r_byte;
   assign byte_valid_o = r_byte_valid;
   assign byte_idx_o   = r_byte_idx;
   assign frame_ok_o   = r_frame_ok;
   assign frame_err_o  = r_frame_err;
   assign err_code_o   = r_err_code;
   assign err_cnt_o    = r_err_cnt;
   assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Directed bench for the frame sequencer. Expected output events (payload
// bytes, frame ok, frame errors) are queued with the cycle they must appear
// in before each byte is driven; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

   localparam int unsigned CLKFREQ = 1_000_000;
   localparam int unsigned BAUD    = 100_000;
   localparam int unsigned TOBYTES = 4;
   localparam int unsigned MAXLEN  = 16;
   localparam int unsigned BYTE_T  = 10 * (CLKFREQ / BAUD);  // 100 clocks
   localparam int unsigned LIMIT   = TOBYTES * BYTE_T;       // 400 clocks

   localparam logic [1:0] K_BYTE = 2'd0;
   localparam logic [1:0] K_OK   = 2'd1;
   localparam logic [1:0] K_ERR  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  data;
      logic [7:0]  idx;
      logic [1:0]  code;
      logic [31:0] cyc;
   } exp_t;

   exp_t q[$];

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [7:0]  rx_data  = 8'd0;
   logic        rx_tick  = 1'b0;
   logic [31:0] cyc      = 32'd0;
   int          total    = 0;
   int          bad      = 0;

   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic [7:0]  byte_idx_o;
   logic        frame_ok_o;
   logic        frame_err_o;
   logic [1:0]  err_code_o;
   logic [7:0]  err_cnt_o;
   logic        busy_o;

   uart_rx_frame_ctrl #(
      .P_CLKFREQ  (CLKFREQ),
      .P_BAUDRATE (BAUD),
      .P_MAXLEN   (MAXLEN),
      .P_SYNC     (8'hA5),
      .P_TOBYTES  (TOBYTES)
   ) dut (
      .clk            (clk),
      .rst_n_i        (rst_n),
      .rx_data_i      (rx_data),
      .rx_done_tick_i (rx_tick),
      .byte_o         (byte_o),
      .byte_valid_o   (byte_valid_o),
      .byte_idx_o     (byte_idx_o),
      .frame_ok_o     (frame_ok_o),
      .frame_err_o    (frame_err_o),
      .err_code_o     (err_code_o),
      .err_cnt_o      (err_cnt_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Output event monitor
   always @(negedge clk) begin : mon
      exp_t       e;
      logic [1:0] k;
      if (byte_valid_o || frame_ok_o || frame_err_o) begin
         if (frame_ok_o || frame_err_o)
            check("ok_err_exclusive", {31'd0, frame_ok_o & frame_err_o}, 32'd0);
         k = byte_valid_o ? K_BYTE : (frame_ok_o ? K_OK : K_ERR);
         if (q.size() == 0) begin
            check("unexpected_event", {29'd0, byte_valid_o, frame_ok_o, frame_err_o}, 32'd0);
         end else begin
            e = q.pop_front();
            check("event_kind", {30'd0, k}, {30'd0, e.kind});
            check("event_cycle", cyc, e.cyc);
            if (e.kind == K_BYTE) begin
               check("byte_o", {24'd0, byte_o}, {24'd0, e.data});
               check("byte_idx_o", {24'd0, byte_idx_o}, {24'd0, e.idx});
            end
            if (e.kind == K_ERR)
               check("err_code_o", {30'd0, err_code_o}, {30'd0, e.code});
         end
      end
   end

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge: tick is sampled by the next posedge
   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
      rx_data = 8'd0;
   endtask

   task automatic push(input logic [1:0] kind, input logic [7:0] d, input logic [7:0] i,
                       input logic [1:0] code, input logic [31:0] at);
      exp_t e;
      e.kind = kind; e.data = d; e.idx = i; e.code = code; e.cyc = at;
      q.push_back(e);
   endtask

   task automatic sb(input logic [7:0] b);
      send(b);
      idle(BYTE_T - 1);
   endtask

   task automatic sbp(input logic [7:0] b, input logic [7:0] i);
      push(K_BYTE, b, i, 2'b00, cyc + 32'd1);
      sb(b);
   endtask

   task automatic sbok(input logic [7:0] b);
      push(K_OK, 8'd0, 8'd0, 2'b00, cyc + 32'd1);
      sb(b);
   endtask

   task automatic sberr(input logic [7:0] b, input logic [1:0] code);
      push(K_ERR, 8'd0, 8'd0, code, cyc + 32'd1);
      sb(b);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_o"},     {24'd0, byte_o},     32'd0);
      check({tag, "_valid"},      {31'd0, byte_valid_o}, 32'd0);
      check({tag, "_idx"},        {24'd0, byte_idx_o}, 32'd0);
      check({tag, "_ok"},         {31'd0, frame_ok_o}, 32'd0);
      check({tag, "_err"},        {31'd0, frame_err_o}, 32'd0);
      check({tag, "_code"},       {30'd0, err_code_o}, 32'd0);
      check({tag, "_cnt"},        {24'd0, err_cnt_o},  32'd0);
      check({tag, "_busy"},       {31'd0, busy_o},     32'd0);
   endtask

   initial begin
      logic [31:0] c;

      // Reset state
      rst_n = 1'b0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Good frame: A5 03 11 22 33 03
      sb(8'hA5);
      check("good_busy_mid", {31'd0, busy_o}, 32'd1);
      sb(8'h03);
      sbp(8'h11, 8'd0);
      sbp(8'h22, 8'd1);
      sbp(8'h33, 8'd2);
      sbok(8'h03);
      check("good_busy_end", {31'd0, busy_o}, 32'd0);
      check("good_err_cnt", {24'd0, err_cnt_o}, 32'd0);
      check("good_drained", q.size(), 32'd0);

      // Leading garbage and zero length: 00 FF A5 00 00
      sb(8'h00);
      sb(8'hFF);
      check("zl_busy_garbage", {31'd0, busy_o}, 32'd0);
      sb(8'hA5);
      check("zl_busy_after_sync", {31'd0, busy_o}, 32'd1);
      sb(8'h00);
      check("zl_busy_after_len", {31'd0, busy_o}, 32'd1);
      sbok(8'h00);
      check("zl_busy_end", {31'd0, busy_o}, 32'd0);
      check("zl_drained", q.size(), 32'd0);

      // Bad checksum: A5 02 AA 55 00 (expected FD)
      sb(8'hA5);
      sb(8'h02);
      sbp(8'hAA, 8'd0);
      sbp(8'h55, 8'd1);
      sberr(8'h00, 2'b10);
      check("chk_code_held", {30'd0, err_code_o}, 32'd2);
      check("chk_err_cnt", {24'd0, err_cnt_o}, 32'd1);

      // Bad length A5 11, then good frame A5 01 7E 7F
      sb(8'hA5);
      sberr(8'h11, 2'b01);
      check("len_code", {30'd0, err_code_o}, 32'd1);
      check("len_err_cnt", {24'd0, err_cnt_o}, 32'd2);
      check("len_busy", {31'd0, busy_o}, 32'd0);
      sb(8'hA5);
      sb(8'h01);
      sbp(8'h7E, 8'd0);
      sbok(8'h7F);
      check("len_code_still_held", {30'd0, err_code_o}, 32'd1);
      check("len_drained", q.size(), 32'd0);

      // Timeout: A5 02 AA then silence; error exactly LIMIT cycles after AA
      sb(8'hA5);
      sb(8'h02);
      push(K_BYTE, 8'hAA, 8'd0, 2'b00, cyc + 32'd1);
      push(K_ERR, 8'd0, 8'd0, 2'b11, cyc + 32'(LIMIT));
      send(8'hAA);
      idle(LIMIT + 10);
      check("to_code", {30'd0, err_code_o}, 32'd3);
      check("to_err_cnt", {24'd0, err_cnt_o}, 32'd3);
      check("to_busy", {31'd0, busy_o}, 32'd0);
      check("to_drained", q.size(), 32'd0);

      // Tick coincident with expiry: byte wins, frame completes
      sb(8'hA5);
      c = cyc;
      send(8'h02);
      while (cyc < c + 32'(LIMIT) - 32'd1) @(negedge clk);
      sbp(8'hAA, 8'd0);
      sbp(8'hBB, 8'd1);
      sbok(8'h13);
      check("coin_err_cnt", {24'd0, err_cnt_o}, 32'd3);
      check("coin_busy", {31'd0, busy_o}, 32'd0);
      check("coin_drained", q.size(), 32'd0);

      // Reset mid-frame: silent drop, everything back to zero
      sb(8'hA5);
      send(8'h02);
      idle(2);
      rst_n = 1'b0;
      idle(2);
      check_all_zero("midrst");
      rst_n = 1'b1;
      idle(LIMIT + 20);
      check("midrst_busy_after", {31'd0, busy_o}, 32'd0);
      check("midrst_cnt_after", {24'd0, err_cnt_o}, 32'd0);
      check("midrst_drained", q.size(), 32'd0);

      // Error counter saturation: 256 bad-length frames back to back
      for (int i = 0; i < 256; i++) begin
         send(8'hA5);
         push(K_ERR, 8'd0, 8'd0, 2'b01, cyc + 32'd1);
         send(8'h11);
      end
      idle(5);
      check("sat_err_cnt", {24'd0, err_cnt_o}, 32'd255);
      check("sat_code", {30'd0, err_code_o}, 32'd1);
      check("sat_drained", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
